// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, helpers and stage-register control fields for
// the pipelined carry-lookahead adder.
//   CLA_GROUP  bits per lookahead group
//   cla_ng()   number of groups (and pipeline stages) for a given width
//   cla_ctl_t  per-stage control fields; the top adds the WIDTH-dependent
//              sum/operand fields around it, since a package struct cannot
//              depend on a module parameter.
package cla_pkg;

  localparam int CLA_GROUP = 4;

  function automatic int cla_ng(input int width);
    return width / CLA_GROUP;
  endfunction

  typedef struct packed {
    logic valid;    // beat present in this stage
    logic carry;    // carry out of this stage's group (stage input: carry in)
    logic msb_cin;  // carry into bit 3 of this stage's group; meaningful at the last stage
  } cla_ctl_t;

endpackage

// File: rtl/cla_group4.sv
// cla_group4: combinational 4-bit carry-lookahead group.
//   a, b  operand nibbles
//   ci    carry in
//   s     sum nibble
//   co    carry out of bit 3
//   c3    carry into bit 3 (overflow detection at the MSB group)
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // All carries are two-level functions of g/p/ci: no ripple inside the group.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (&p & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];
  assign c3 = c[3];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, one 4-bit group
// per stage, valid/ready stream interface with full backpressure.
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    operand beat handshake
//   a, b, cin, sub       operands; sub=1 computes a+~b+1 and ignores cin
//   out_valid/out_ready  result beat handshake
//   sum, cout, ovf       result, carry out of MSB, signed overflow
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = cla_ng(WIDTH);

  if ((WIDTH % CLA_GROUP) != 0 || WIDTH < CLA_GROUP || GROUP != CLA_GROUP) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4 and GROUP must be 4");
  end

  typedef struct packed {
    cla_ctl_t         ctl;
    logic [WIDTH-1:0] sum;   // groups 0..k finished, above that still zero
    logic [WIDTH-1:0] a_up;  // operand A, upper slices consumed by later stages
    logic [WIDTH-1:0] b_up;  // operand B, already inverted for subtraction
  } stage_t;

  stage_t          src  [NG];  // input seen by each stage
  stage_t          st_d [NG];
  stage_t          st_q [NG];
  logic [NG-1:0][3:0] gs;
  logic [NG-1:0]   gco;
  logic [NG-1:0]   gc3;
  logic            advance;

  // The whole pipe moves or holds as one; bubbles are never collapsed.
  assign advance  = !st_q[NG-1].ctl.valid | out_ready;
  assign in_ready = advance;

  always_comb begin
    src[0]           = '0;
    src[0].ctl.valid = in_valid;
    src[0].ctl.carry = sub | cin;  // subtract folds the +1 into the carry in
    src[0].a_up      = a;
    src[0].b_up      = sub ? ~b : b;
    for (int k = 1; k < NG; k++) src[k] = st_q[k-1];
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .a  (src[k].a_up[k*4 +: 4]),
      .b  (src[k].b_up[k*4 +: 4]),
      .ci (src[k].ctl.carry),
      .s  (gs[k]),
      .co (gco[k]),
      .c3 (gc3[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NG; k++) begin
      st_d[k]              = src[k];
      st_d[k].sum[k*4 +: 4] = gs[k];
      st_d[k].ctl.carry    = gco[k];
      st_d[k].ctl.msb_cin  = gc3[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NG; k++) st_q[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < NG; k++) st_q[k] <= st_d[k];
    end
  end

  // Outputs come straight from the last stage register.
  assign out_valid = st_q[NG-1].ctl.valid;
  assign sum       = st_q[NG-1].sum;
  assign cout      = st_q[NG-1].ctl.carry;
  assign ovf       = st_q[NG-1].ctl.carry ^ st_q[NG-1].ctl.msb_cin;

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16;
  logic [15:0] a16, b16, s16;
  logic        iv4, ir4, cin4, sub4, ov4, or4, co4, of4;
  logic [3:0]  a4, b4, s4;

  int checks   = 0;
  int failures = 0;
  int retired  = 0;

  // Reference pipe for the 16-bit instance: a beat shows up 3 moves after it
  // is accepted, and everything freezes while the head is valid and not taken.
  logic        m_v [4];
  logic [17:0] m_r [4];

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
    .cout(co16), .ovf(of16));

  cla_pipe_adder #(.WIDTH(4), .GROUP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(s4),
    .cout(co4), .ovf(of4));

  always #5 clk = ~clk;

  // Result packed as {ovf, cout, sum[15:0]} from plain integer arithmetic.
  function automatic logic [17:0] calc(input int w, input logic [15:0] a, input logic [15:0] b,
                                       input logic c, input logic s);
    longint m, half, ua, ub, full, sa, sb, sr;
    logic [17:0] r;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(a) & m;
    ub   = longint'(b) & m;
    if (s) begin
      full  = ua - ub;
      r[16] = (ua >= ub);
    end else begin
      full  = ua + ub + longint'(c);
      r[16] = ((full >> w) & 1) != 0;
    end
    r[15:0] = 16'(full & m);
    sa = (ua >= half) ? ua - (m + 1) : ua;
    sb = (ub >= half) ? ub - (m + 1) : ub;
    sr = s ? (sa - sb) : (sa + sb + longint'(c));
    r[17] = (sr >= half) || (sr < -half);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_v[i] <= 1'b0; m_r[i] <= '0; end
    end else if (!m_v[3] || or16) begin
      for (int i = 3; i > 0; i--) begin m_v[i] <= m_v[i-1]; m_r[i] <= m_r[i-1]; end
      m_v[0] <= iv16;
      m_r[0] <= calc(16, a16, b16, cin16, sub16);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 32'(ir16), 32'(!m_v[3] || or16));
      chk("out_valid", 32'(ov16), 32'(m_v[3]));
      if (m_v[3] && ov16) chk("result", 32'({of16, co16, s16}), 32'(m_r[3]));
      if (ov16 && or16) retired++;
    end
  end

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                       input logic [17:0] exp, input string nm);
    chk({nm, "_model"}, 32'(calc(16, a, b, c, s)), 32'(exp));
    @(posedge clk); #1;
    iv16 = 1'b1; a16 = a; b16 = b; cin16 = c; sub16 = s; or16 = 1'b1;
    @(posedge clk); #1;  // accepted at this edge
    iv16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_valid"}, 32'(ov16), 32'd1);
    chk(nm, 32'({of16, co16, s16}), 32'(exp));
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic s,
                      input logic [17:0] exp, input string nm);
    chk({nm, "_model"}, 32'(calc(4, {12'b0, a}, {12'b0, b}, c, s)), 32'(exp));
    @(posedge clk); #1;
    iv4 = 1'b1; a4 = a; b4 = b; cin4 = c; sub4 = s;
    @(negedge clk);
    chk({nm, "_pre"}, 32'(ov4), 32'd0);
    @(posedge clk); #1;
    iv4 = 1'b0;
    chk({nm, "_valid"}, 32'(ov4), 32'd1);
    chk(nm, 32'({of4, co4, 12'b0, s4}), 32'(exp));
  endtask

  task automatic stream_test();
    logic [15:0] sa [6];
    logic [15:0] sb [6];
    logic        sc [6];
    logic        ss [6];
    logic [17:0] snap;
    logic        acc;
    int idx = 0, stall_cnt = 0, cyc = 0, base;
    sa = '{16'h1000, 16'hFFFF, 16'h0003, 16'h8000, 16'h1234, 16'h7FFF};
    sb = '{16'h0234, 16'h0001, 16'h0004, 16'h8000, 16'h1234, 16'h7FFF};
    sc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ss = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    snap = '0;
    base = retired;
    @(posedge clk); #1;
    while ((retired - base) < 6 && cyc < 40) begin
      if (idx < 6 && cyc != 2 && cyc != 3) begin
        iv16 = 1'b1; a16 = sa[idx]; b16 = sb[idx]; cin16 = sc[idx]; sub16 = ss[idx];
      end else begin
        iv16 = 1'b0;
      end
      if (ov16 && stall_cnt < 3) begin
        if (stall_cnt == 0) snap = {of16, co16, s16};
        or16 = 1'b0;
        stall_cnt++;
        #1;
        chk("stall_in_ready", 32'(ir16), 32'd0);
        if (stall_cnt > 1) chk("stall_hold", 32'({of16, co16, s16}), 32'(snap));
      end else begin
        or16 = 1'b1;
      end
      @(negedge clk);
      acc = iv16 & ir16;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    iv16 = 1'b0; or16 = 1'b1;
    chk("stream_retired", 32'(retired - base), 32'd6);
    chk("stream_accepted", 32'(idx), 32'd6);
    chk("stream_stalled", 32'(stall_cnt), 32'd3);
  endtask

  task automatic reset_test();
    int stale = 0;
    or16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b1; a16 = 16'h0011; b16 = 16'h0022; cin16 = 1'b0; sub16 = 1'b0;
    @(posedge clk); #1; a16 = 16'h0033;
    @(posedge clk); #1; a16 = 16'h0055;
    @(posedge clk); #1; iv16 = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_valid", 32'(ov16), 32'd1);
    or16 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(ov16), 32'd0);
    chk("rst_mid_sum", 32'(s16), 32'd0);
    chk("rst_mid_flags", 32'({of16, co16}), 32'd0);
    chk("rst_mid_in_ready", 32'(ir16), 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    or16 = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ov16) stale++;
    end
    chk("rst_no_stale", 32'(stale), 32'd0);
    run16(16'h1234, 16'h1111, 1'b0, 1'b0, {2'b00, 16'h2345}, "post_rst");
  endtask

  initial begin
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
    iv4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; sub4  = 1'b0; or4  = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("reset_out_valid", 32'(ov16), 32'd0);
    chk("reset_sum", 32'(s16), 32'd0);
    chk("reset_flags", 32'({of16, co16}), 32'd0);
    chk("reset_in_ready", 32'(ir16), 32'd1);
    chk("reset_out_valid4", 32'(ov4), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    run16(16'h00FF, 16'h0001, 1'b0, 1'b0, {2'b00, 16'h0100}, "add_ripple");
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, {2'b01, 16'h0000}, "wrap");
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, {2'b10, 16'h8000}, "pos_ovf");
    run16(16'h0FFF, 16'h0001, 1'b1, 1'b0, {2'b00, 16'h1001}, "add_cin");
    run16(16'h0005, 16'h0007, 1'b1, 1'b1, {2'b00, 16'hFFFE}, "sub_borrow");
    run16(16'h8000, 16'h0001, 1'b0, 1'b1, {2'b11, 16'h7FFF}, "sub_ovf");

    stream_test();
    reset_test();

    run4(4'hF, 4'h1, 1'b0, 1'b0, {2'b01, 16'h0000}, "w4_wrap");
    run4(4'hA, 4'h5, 1'b1, 1'b0, {2'b01, 16'h0000}, "w4_cin");
    run4(4'hF, 4'hF, 1'b1, 1'b0, {2'b01, 16'h000F}, "w4_ones");
    run4(4'h7, 4'h1, 1'b0, 1'b0, {2'b10, 16'h0008}, "w4_ovf");
    run4(4'h3, 4'h5, 1'b1, 1'b1, {2'b00, 16'h000E}, "w4_sub");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
